db_multi_debounce: RTL and testbench

Parametrised multi-channel debouncer for the ARTY A7 front-panel switches and buttons. It synchronises N_CH asynchronous inputs and filters each one independently. All channels share one prescaler tick. Each channel drives a clean level plus optional single-cycle rise/fall strobes to the run-control and trigger-configuration logic. It supersedes the single-channel fixed-timing debouncer.

---
 rtl/db_pkg.sv | 14 +
 rtl/db_channel.sv | 110 +++++++++++
 rtl/db_multi_debounce.sv | 46 ++++
 tb/tb_db_multi_debounce.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// Shared types and default timing constants for the multi-channel debouncer.
package db_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        WAIT_HI = 2'd1,
        HIGH    = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    localparam int DB_DIV_BITS_DEF = 20;
    localparam int DB_N_TICKS_DEF  = 3;

endpackage

// File: rtl/db_channel.sv
// One debounce channel: 2-flop synchroniser, confirm FSM and optional edge strobes.
// Edge strobe registers are only built when DB_EDGE_EN is defined.
module db_channel
    import db_pkg::*;
#(
    parameter int N_TICKS = DB_N_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sw_in,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_TICKS - 1);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    db_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic s;

    assign s = sync2_q;

    always_comb begin
        sync1_d = sw_in;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            // Input level is checked before the tick so a bounce always aborts.
            WAIT_HI: begin
                if (!s)
                    state_d = LOW;
                else if (tick) begin
                    if (cnt_q == CNT_LAST) state_d = HIGH;
                    else                   cnt_d   = cnt_q + CW'(1);
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s)
                    state_d = HIGH;
                else if (tick) begin
                    if (cnt_q == CNT_LAST) state_d = LOW;
                    else                   cnt_d   = cnt_q + CW'(1);
                end
            end
            default: state_d = LOW;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = (state_q == HIGH) || (state_q == WAIT_LO);

`ifdef DB_EDGE_EN
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Strobes are registered alongside the state so they line up with the db edge.
    always_comb begin
        rise_d = (state_q == WAIT_HI) && (state_d == HIGH);
        fall_d = (state_q == WAIT_LO) && (state_d == LOW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/db_multi_debounce.sv
// Multi-channel debouncer: shared prescaler tick feeding N_CH independent channels.
// Optional feature macro: DB_EDGE_EN (builds the rise/fall strobe registers).
module db_multi_debounce
    import db_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DIV_BITS = DB_DIV_BITS_DEF,
    parameter int N_TICKS  = DB_N_TICKS_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick
);

    logic [DIV_BITS-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q + DIV_BITS'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign tick = (q_q == '0);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_channel #(
            .N_TICKS(N_TICKS)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .tick (tick),
            .sw_in(sw[i]),
            .db   (db[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule

// File: tb/tb_db_multi_debounce.sv
// Scoreboard bench: stimulus queues expected db/strobe events, a monitor checks them.
module tb_db_multi_debounce;
    import db_pkg::*;

    localparam int N_CH = 2;
    localparam int DIV_BITS = 4;
    localparam int N_TICKS = 3;
    localparam int TP = 1 << DIV_BITS;
`ifdef DB_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    typedef struct {
        logic [N_CH-1:0] db;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
        int              cyc;
    } ev_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N_CH-1:0] sw = '0;
    logic [N_CH-1:0] db, rise, fall;
    logic            tick;

    int  cyc = 0;
    int  r_rel = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    ev_t exp_q[$];
    logic [N_CH-1:0] prev_db = '0;

    db_multi_debounce #(.N_CH(N_CH), .DIV_BITS(DIV_BITS), .N_TICKS(N_TICKS)) u_dut (
        .clk(clk), .reset(reset), .sw(sw), .db(db), .rise(rise), .fall(fall), .tick(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Edge at which db changes for an s-level change driven at cycle t0:
    // WAIT state from edge t0+3, then the third tick edge at or after t0+4 confirms.
    function automatic int acc_cyc(input int t0);
        int e;
        e = t0 + 4;
        while (((e - r_rel - 1) % TP) != 0) e++;
        return e + (N_TICKS - 1) * TP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input logic [N_CH-1:0] d, input logic [N_CH-1:0] r,
                             input logic [N_CH-1:0] f, input int c);
        ev_t e;
        e.db = d;
        e.rise = EDGE ? r : '0;
        e.fall = EDGE ? f : '0;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        ev_t e;
        #1;
        if (db !== prev_db || rise !== '0 || fall !== '0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: db=%b rise=%b fall=%b at cycle %0d, none expected",
                         db, rise, fall, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("ev_db", 32'(db), 32'(e.db));
                chk("ev_rise", 32'(rise), 32'(e.rise));
                chk("ev_fall", 32'(fall), 32'(e.fall));
                chk("ev_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_db = db;
    end

    initial begin
        int t;
        #1 reset = 1'b1;
        step(3);
        chk("rst_db", 32'(db), 32'd0);
        chk("rst_rise", 32'(rise), 32'd0);
        chk("rst_fall", 32'(fall), 32'd0);
        chk("rst_state0", 32'(u_dut.g_ch[0].u_ch.state_q), 32'(LOW));
        reset = 1'b0;
        r_rel = cyc;
        step(1);
        chk("first_tick_seen", 32'(u_dut.q_q), 32'd1);

        // Clean press on channel 0
        t = cyc;
        sw = 2'b01;
        expect_ev(2'b01, 2'b01, 2'b00, acc_cyc(t));
        chk("clean_window_lo", 32'(acc_cyc(t) - t >= 36), 32'd1);
        chk("clean_window_hi", 32'(acc_cyc(t) - t <= 51), 32'd1);
        step(200);

        // 20-cycle glitch low is rejected, then a long low is accepted
        sw = 2'b00;
        step(20);
        sw = 2'b01;
        step(40);
        t = cyc;
        sw = 2'b00;
        expect_ev(2'b00, 2'b00, 2'b01, acc_cyc(t));
        step(60);
        step(20);

        // 5-cycle bounce train, then steady low
        for (int i = 0; i < 15; i++) begin
            sw = 2'b01;
            step(5);
            sw = 2'b00;
            step(5);
        end
        step(80);

        // Both channels rise together
        t = cyc;
        sw = 2'b11;
        expect_ev(2'b11, 2'b11, 2'b00, acc_cyc(t));
        step(70);

        // Reset while HIGH: db drops asynchronously without a strobe
        expect_ev(2'b00, 2'b00, 2'b00, cyc + 1);
        reset = 1'b1;
        #1;
        chk("rst_high_db", 32'(db), 32'd0);
        chk("rst_high_state1", 32'(u_dut.g_ch[1].u_ch.state_q), 32'(LOW));
        step(3);
        reset = 1'b0;
        r_rel = cyc;
        expect_ev(2'b11, 2'b11, 2'b00, acc_cyc(r_rel));
        chk("rst_refill_window", 32'(acc_cyc(r_rel) - r_rel), 32'd49);
        step(70);

        // Release both, then reset channel 0 mid-confirm
        t = cyc;
        sw = 2'b00;
        expect_ev(2'b00, 2'b00, 2'b11, acc_cyc(t));
        step(60);
        sw = 2'b01;
        step(10);
        chk("pre_rst_waithi", 32'(u_dut.g_ch[0].u_ch.state_q), 32'(WAIT_HI));
        reset = 1'b1;
        #1;
        chk("rst_waithi_state", 32'(u_dut.g_ch[0].u_ch.state_q), 32'(LOW));
        chk("rst_waithi_db", 32'(db), 32'd0);
        step(2);
        reset = 1'b0;
        r_rel = cyc;
        expect_ev(2'b01, 2'b01, 2'b00, acc_cyc(r_rel));
        step(70);

        chk("pending_events", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
